hazard_ctrl: RTL and testbench

- Central hazard and pipeline-control unit for the 5-stage MIPS-style core.
- Drives the stall/flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Generates EX-stage forwarding selects.
- Sequences multi-cycle divide stalls, data-memory wait stalls and exception flushes.

---
 rtl/hazard_ctrl.sv | 175 +++++++++++++++++
 tb/tb_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage core: forwarding, load-use/branch
// bubbles, divide sequencing, memory-wait freezes and exception flushes. Option: HAZARD_PERF_CNT_EN.
module hazard_ctrl #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_branch,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic       ex_we,
    input  logic [4:0] ex_wreg,
    input  logic       ex_mem_read,
    input  logic       ex_div_start,
    input  logic       mem_we,
    input  logic [4:0] mem_wreg,
    input  logic       mem_mem_read,
    input  logic       mem_req,
    input  logic       mem_data_ok,
    input  logic       wb_we,
    input  logic [4:0] wb_wreg,
    input  logic       exc_valid,
    output logic       stall_pc,
    output logic       stall_ifid,
    output logic       stall_idex,
    output logic       stall_exmem,
    output logic       stall_memwb,
    output logic       flush_ifid,
    output logic       flush_idex,
    output logic       flush_exmem,
    output logic       flush_memwb,
    output logic       pc_exc_redirect,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       div_busy
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_lu_events
`endif
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DIV_BUSY,
        DIV_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic id_hits_ex;
    logic id_hits_mem;
    logic lu;
    logic br;
    logic mw;
    logic busy_st;

    // A producer register matches when it is non-zero and read by the ID instruction
    assign id_hits_ex  = (ex_wreg != 5'd0) &&
                         ((id_use_rs && (id_rs == ex_wreg)) || (id_use_rt && (id_rt == ex_wreg)));
    assign id_hits_mem = (mem_wreg != 5'd0) &&
                         ((id_use_rs && (id_rs == mem_wreg)) || (id_use_rt && (id_rt == mem_wreg)));

    assign lu      = ex_mem_read && id_hits_ex;
    assign br      = id_branch && ((ex_we && id_hits_ex) || (mem_mem_read && id_hits_mem));
    assign mw      = mem_req && !mem_data_ok;
    assign busy_st = (state == DIV_BUSY);

    // Divide sequencer; an exception aborts any divide in flight
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (exc_valid) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ex_div_start && !mw) begin
                        state <= DIV_BUSY;
                        cnt   <= CNT_LOAD;
                    end
                end
                DIV_BUSY: begin
                    if (cnt == '0) begin
                        state <= DIV_DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DIV_DONE: begin
                    if (!stall_idex) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Control outputs; a flush is dropped when a higher-priority stall freezes that register
    always_comb begin
        stall_pc        = 1'b0;
        stall_ifid      = 1'b0;
        stall_idex      = 1'b0;
        stall_exmem     = 1'b0;
        stall_memwb     = 1'b0;
        flush_ifid      = 1'b0;
        flush_idex      = 1'b0;
        flush_exmem     = 1'b0;
        flush_memwb     = 1'b0;
        pc_exc_redirect = 1'b0;
        fwd_a           = 2'b00;
        fwd_b           = 2'b00;
        div_busy        = 1'b0;
        if (resetn) begin
            if (mem_we && (mem_wreg != 5'd0) && (mem_wreg == ex_rs)) begin
                fwd_a = 2'b01;
            end else if (wb_we && (wb_wreg != 5'd0) && (wb_wreg == ex_rs)) begin
                fwd_a = 2'b10;
            end
            if (mem_we && (mem_wreg != 5'd0) && (mem_wreg == ex_rt)) begin
                fwd_b = 2'b01;
            end else if (wb_we && (wb_wreg != 5'd0) && (wb_wreg == ex_rt)) begin
                fwd_b = 2'b10;
            end
            div_busy = busy_st;
            if (exc_valid) begin
                flush_ifid      = 1'b1;
                flush_idex      = 1'b1;
                flush_exmem     = 1'b1;
                flush_memwb     = 1'b1;
                pc_exc_redirect = 1'b1;
            end else begin
                stall_exmem = mw;
                flush_memwb = mw;
                stall_idex  = mw || busy_st;
                flush_exmem = busy_st && !mw;
                stall_pc    = mw || busy_st || lu || br;
                stall_ifid  = mw || busy_st || lu || br;
                flush_idex  = (lu || br) && !(mw || busy_st);
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    // Free-running event counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (!resetn) begin
            perf_stall_cycles <= '0;
            perf_lu_events    <= '0;
        end else begin
            if (stall_pc) begin
                perf_stall_cycles <= perf_stall_cycles + 32'd1;
            end
            if (lu || br) begin
                perf_lu_events <= perf_lu_events + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: rule-level model compared every cycle, plus
// hand-computed expectations along a directed sequence.
module tb_hazard_ctrl;

    localparam int unsigned DIV_CYCLES = 32;
    localparam int unsigned CNT_W      = 6;

    // Bit positions in the packed output vector
    localparam logic [14:0] SPC  = 15'h4000;
    localparam logic [14:0] SIF  = 15'h2000;
    localparam logic [14:0] SIE  = 15'h1000;
    localparam logic [14:0] SEM  = 15'h0800;
    localparam logic [14:0] FIF  = 15'h0200;
    localparam logic [14:0] FIE  = 15'h0100;
    localparam logic [14:0] FEM  = 15'h0080;
    localparam logic [14:0] FMW  = 15'h0040;
    localparam logic [14:0] RED  = 15'h0020;
    localparam logic [14:0] FA01 = 15'h0008;
    localparam logic [14:0] FB10 = 15'h0004;
    localparam logic [14:0] BUSY = 15'h0001;

    logic       clk;
    logic       resetn;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wreg, mem_wreg, wb_wreg;
    logic       id_use_rs, id_use_rt, id_branch, ex_we, ex_mem_read, ex_div_start;
    logic       mem_we, mem_mem_read, mem_req, mem_data_ok, wb_we, exc_valid;
    logic       stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb;
    logic       flush_ifid, flush_idex, flush_exmem, flush_memwb, pc_exc_redirect, div_busy;
    logic [1:0] fwd_a, fwd_b;
    logic [14:0] got;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_lu_events;
    logic [31:0] m_perf_stall = '0;
    logic [31:0] m_perf_lu    = '0;
`endif

    int tests = 0;
    int fails = 0;

    // Model state: remaining busy cycles of the divider and the result-ready flag
    int m_busy_left = 0;
    bit m_done      = 1'b0;

    hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
        .clk(clk), .resetn(resetn),
        .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_branch(id_branch), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_we(ex_we),
        .ex_wreg(ex_wreg), .ex_mem_read(ex_mem_read), .ex_div_start(ex_div_start),
        .mem_we(mem_we), .mem_wreg(mem_wreg), .mem_mem_read(mem_mem_read),
        .mem_req(mem_req), .mem_data_ok(mem_data_ok), .wb_we(wb_we), .wb_wreg(wb_wreg),
        .exc_valid(exc_valid),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
        .stall_exmem(stall_exmem), .stall_memwb(stall_memwb),
        .flush_ifid(flush_ifid), .flush_idex(flush_idex), .flush_exmem(flush_exmem),
        .flush_memwb(flush_memwb), .pc_exc_redirect(pc_exc_redirect),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .div_busy(div_busy)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_lu_events(perf_lu_events)
`endif
    );

    assign got = {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
                  flush_ifid, flush_idex, flush_exmem, flush_memwb, pc_exc_redirect,
                  fwd_a, fwd_b, div_busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit reads_id(input logic [4:0] r);
        return (r != 5'd0) && ((id_use_rs && id_rs == r) || (id_use_rt && id_rt == r));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (mem_we && mem_wreg != 5'd0 && mem_wreg == src) return 2'b01;
        if (wb_we && wb_wreg != 5'd0 && wb_wreg == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit hazard_any();
        bit lu, br;
        lu = ex_mem_read && reads_id(ex_wreg);
        br = id_branch && ((ex_we && reads_id(ex_wreg)) || (mem_mem_read && reads_id(mem_wreg)));
        return lu || br;
    endfunction

    // Expected outputs from the priority rules: exception > memory wait > divide > LU/BR
    function automatic logic [14:0] expect_out();
        bit hz, mw, busy, frz_idex;
        logic [14:0] e;
        e = '0;
        if (!resetn) return e;
        hz   = hazard_any();
        mw   = mem_req && !mem_data_ok;
        busy = (m_busy_left > 0);
        e[4:3] = fwd_sel(ex_rs);
        e[2:1] = fwd_sel(ex_rt);
        e[0]   = busy;
        if (exc_valid) begin
            e = e | FIF | FIE | FEM | FMW | RED;
        end else begin
            frz_idex = mw || busy;
            if (mw) e = e | SEM | FMW;
            if (frz_idex) e = e | SIE;
            if (busy && !mw) e = e | FEM;
            if (frz_idex || hz) e = e | SPC | SIF;
            if (hz && !frz_idex) e = e | FIE;
        end
        return e;
    endfunction

    always @(posedge clk) begin
        logic [14:0] e;
        e = expect_out();
        if (!resetn || exc_valid) begin
            m_busy_left <= 0;
            m_done      <= 1'b0;
        end else if (m_busy_left > 0) begin
            m_busy_left <= m_busy_left - 1;
            if (m_busy_left == 1) m_done <= 1'b1;
        end else if (m_done) begin
            if (!e[12]) m_done <= 1'b0;
        end else if (ex_div_start && !(mem_req && !mem_data_ok)) begin
            m_busy_left <= DIV_CYCLES;
        end
`ifdef HAZARD_PERF_CNT_EN
        if (!resetn) begin
            m_perf_stall <= '0;
            m_perf_lu    <= '0;
        end else begin
            m_perf_stall <= m_perf_stall + 32'(e[14]);
            m_perf_lu    <= m_perf_lu + 32'(hazard_any());
        end
`endif
    end

    always @(negedge clk) begin
        check("cycle_model", 32'(got), 32'(expect_out()));
`ifdef HAZARD_PERF_CNT_EN
        check("perf_stall_cycles", perf_stall_cycles, m_perf_stall);
        check("perf_lu_events", perf_lu_events, m_perf_lu);
`endif
    end

    task automatic clr();
        id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0; id_branch = 0;
        ex_rs = '0; ex_rt = '0; ex_we = 0; ex_wreg = '0; ex_mem_read = 0; ex_div_start = 0;
        mem_we = 0; mem_wreg = '0; mem_mem_read = 0; mem_req = 0; mem_data_ok = 0;
        wb_we = 0; wb_wreg = '0; exc_valid = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic look(input string name, input logic [14:0] exp);
        #2;
        check(name, 32'(got), 32'(exp));
    endtask

    initial begin
        resetn = 1'b0;
        clr();
        // Inputs that would otherwise produce activity must be masked in reset
        mem_we = 1; mem_wreg = 5; ex_rs = 5; mem_req = 1; ex_div_start = 1; exc_valid = 1;
        next(); look("reset_outputs", '0);
        next(); look("reset_outputs_2", '0);

        next(); resetn = 1'b1; clr();
        ex_mem_read = 1; ex_wreg = 3; id_rs = 3; id_use_rs = 1;
        look("load_use", SPC | SIF | FIE);
        next(); clr(); look("load_use_release", '0);

        next(); mem_we = 1; mem_wreg = 5; wb_we = 1; wb_wreg = 5; ex_rs = 5;
        look("fwd_mem_wins", FA01);
        next(); mem_wreg = 0; wb_wreg = 0; look("fwd_reg0", '0);
        next(); clr(); wb_we = 1; wb_wreg = 7; ex_rt = 7; look("fwd_b_wb", FB10);

        next(); clr(); id_branch = 1; id_rt = 4; id_use_rt = 1; ex_we = 1; ex_wreg = 4;
        look("branch_ex", SPC | SIF | FIE);
        next(); id_use_rt = 0; look("branch_unused_src", '0);
        next(); clr(); id_branch = 1; id_rs = 9; id_use_rs = 1; mem_mem_read = 1; mem_wreg = 9;
        look("branch_mem_load", SPC | SIF | FIE);

        next(); clr(); ex_div_start = 1; look("div_start_cycle", '0);
        for (int i = 1; i <= 32; i++) begin
            next(); look("div_busy_cycle", BUSY | FEM | SPC | SIF | SIE);
        end
        next(); look("div_done_33", '0);
        next(); ex_div_start = 0; look("div_idle", '0);
        next(); look("div_idle_2", '0);

        next(); mem_req = 1; ex_div_start = 1;
        look("mw_blocks_div", SPC | SIF | SIE | SEM | FMW);
        next(); mem_data_ok = 1; look("div_start_after_mw", '0);
        next(); mem_req = 0; mem_data_ok = 0;
        look("div_busy_after_mw", BUSY | FEM | SPC | SIF | SIE);
        next(); mem_req = 1; look("mw_in_div", BUSY | SPC | SIF | SIE | SEM | FMW);
        next(); mem_req = 0;
        for (int i = 0; i < 7; i++) next();
        exc_valid = 1; look("exc_in_div", BUSY | FIF | FIE | FEM | FMW | RED);
        next(); exc_valid = 0; ex_div_start = 0; look("exc_aborted", '0);

        next(); clr(); mem_req = 1; ex_mem_read = 1; ex_wreg = 3; id_rs = 3; id_use_rs = 1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next();
            look("mem_wait", SPC | SIF | SIE | SEM | FMW);
        end
        next(); mem_data_ok = 1; look("mem_wait_release", SPC | SIF | FIE);
        next(); clr(); look("mem_wait_quiet", '0);

        next(); ex_div_start = 1;
        for (int i = 0; i < 5; i++) next();
        look("div_before_reset", BUSY | FEM | SPC | SIF | SIE);
        next(); resetn = 1'b0; look("reset_mid_div", '0);
        next(); look("reset_mid_div_2", '0);
        next(); resetn = 1'b1; ex_div_start = 0; look("post_reset_idle", '0);
        next(); look("post_reset_idle_2", '0);

        next(); next();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
